tqvp_jnms_pdm_tx: RTL and testbench
===================================

# tqvp_jnms_pdm_tx

PDM transmitter peripheral for the TinyQV peripheral bus. The CPU writes signed 16-bit PCM samples into a 4-entry FIFO. The block converts each sample to a 1-bit pulse-density stream with a first-order sigma-delta modulator and drives a PDM clock and data pair on the output PMOD. It is the output-side counterpart of the PDM microphone receiver and uses the same bus and PMOD conventions.

## Interface
- No parameters. FIFO depth is fixed at 4.
- clk  in  1  system clock, nominally 64 MHz
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  unused
- uo_out  out  8  [1]=pdm_clk, [2]=pdm_data, all other bits 0
- address  in  6  register address
- data_in  in  32  write data
- data_write_n  in  2  11=none, 00=8b, 01=16b, 10=32b
- data_read_n  in  2  unused; reads have no side effects
- data_out  out  32  read data, combinational from address
- data_ready  out  1  constant 1
- user_interrupt  out  1  FIFO low-water interrupt, level-sensitive

## Operation
- Register map. Unlisted addresses read 0 and ignore writes. Byte lanes follow the standard width rules.
  - 0x00 CTRL, R/W: [0] EN, [1] IRQ_EN.
  - 0x04 HALF, R/W, [7:0]: pdm_clk half-period in clk cycles = HALF+1. HALF=0 is legal and gives clk/2.
  - 0x08 OSR, R/W, [7:0]: number of PDM bits per sample = OSR+1.
  - 0x0C DATA, W: a 16- or 32-bit write pushes data_in[15:0]. 8-bit writes are ignored. Reads return 0.
  - 0x10 STATUS: [2:0] level (0..4), [8] full, [9] empty, [16] underrun (sticky), [17] overflow (sticky). Writing 1 to bit 16 or 17 clears that bit. Other bits are read-only.
  - 0x14 THRESH, R/W, [2:0].
- Reset values: all registers, FIFO pointers, level, accumulator, current sample, counters, pdm_clk and pdm_data are 0. The FIFO reads empty after reset.
- FIFO behaviour:
  - A push when full is dropped and sets overflow.
  - A pop when empty sets underrun. The current sample becomes 0x0000, which gives a 50% density.
  - Push and pop in the same cycle:
    - When full, both succeed and the level stays at 4.
    - When empty, the pop underruns and the push succeeds, leaving the level at 1.
- Modulator, per step:
  - u = sample ^ 0x8000, giving offset-binary.
  - s = {1'b0, acc} + u, 17 bits wide.
  - pdm_data <= s[16]; acc <= s[15:0].
- Sample fetch: on a step where osr_cnt==0, the FIFO head is popped and used in that same step. osr_cnt then wraps at OSR.
- EN=0: pdm_clk=0, pdm_data=0, div_cnt=0, osr_cnt=0, acc=0. FIFO contents and the sticky bits are retained.
- Clearing EN mid-stream forces the idle state on the next cycle. A partially used sample is discarded.
- user_interrupt = IRQ_EN & EN & (level <= THRESH).

## Timing
- div_cnt counts 0..HALF while EN=1. pdm_clk toggles on the cycle after div_cnt==HALF.
- A step happens in two cases:
  - Priming step: the first cycle with EN=1, while pdm_clk is 0.
  - Every cycle where div_cnt==HALF and pdm_clk==1, i.e. the falling edge.
- On every step, pdm_data and the falling pdm_clk update on the same clk edge. Data is therefore stable for HALF+1 cycles before each rising edge, so the receiver samples on the rising edge.
- First pdm_clk rise occurs HALF+1 cycles after the priming step.
- DATA write: the level increments on the clk edge that captures the write. The pushed value is eligible for a pop on the next cycle.
- STATUS reflects the registered level with no lag. The interrupt follows the level within the same cycle.
- Changing HALF or OSR while EN=1 takes effect at the next counter compare. No glitch protection is required.

## Structure
- Shared package: register address constants (0x00..0x14), the STATUS bit positions, FIFO_DEPTH=4, SAMPLE_W=16.
- Sub-module pdm_tx_fifo: 4x16 FIFO with push, pop, rdata, level[2:0], full and empty outputs. It has no overflow or underrun logic; those flags stay in the top level.
- Top level contains the register file, clock divider, OSR counter, modulator and interrupt logic.

## Test plan
- Reset: all registers read 0, STATUS=0x200, uo_out=0, user_interrupt=0.
- HALF=1, OSR=3, push 0x4000, EN=1 → pdm_data on successive rising edges is 0,1,1,1. Then underrun sets, and the output continues with mid-scale (0x0000) data at 50% density.
- Push 0x8000 (full negative) → pdm_data all 0 for OSR+1 bits. Push 0x7FFF → 0xFFFF/0x10000 density, i.e. a 1 on every bit after the first.
- Push 5 samples with EN=0 → level=4, full=1, overflow=1. Write 0x20000 to STATUS → overflow clears, level stays 4.
- THRESH=1, IRQ_EN=1, EN=1, 3 samples queued → irq is 0. It goes to 1 in the cycle the level becomes 1, and returns to 0 after the next push.
- Clear EN mid-sample → pdm_clk and pdm_data are 0 on the next cycle. Re-enable → the priming step pops a fresh sample and acc restarts from 0.

Source files
------------

// File: rtl/tqvp_jnms_pdm_tx_pkg.sv
// Shared constants for the PDM transmitter: register map, STATUS layout, FIFO geometry.
package tqvp_jnms_pdm_tx_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int SAMPLE_W   = 16;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_HALF   = 6'h04;
    localparam logic [5:0] ADDR_OSR    = 6'h08;
    localparam logic [5:0] ADDR_DATA   = 6'h0C;
    localparam logic [5:0] ADDR_STATUS = 6'h10;
    localparam logic [5:0] ADDR_THRESH = 6'h14;

    localparam int ST_FULL     = 8;
    localparam int ST_EMPTY    = 9;
    localparam int ST_UNDERRUN = 16;
    localparam int ST_OVERFLOW = 17;

    // Two's complement to offset-binary conversion mask.
    localparam logic [SAMPLE_W-1:0] SIGN_FLIP = 16'h8000;

    typedef enum logic [1:0] {
        WR_BYTE = 2'b00,
        WR_HALF = 2'b01,
        WR_WORD = 2'b10,
        WR_NONE = 2'b11
    } wr_size_e;

endpackage

// File: rtl/tqvp_jnms_pdm_tx_fifo.sv
// 4-entry sample FIFO. Push while full succeeds only when a pop happens in the same cycle.
module pdm_tx_fifo
    import tqvp_jnms_pdm_tx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] wdata,
    output logic [SAMPLE_W-1:0] rdata,
    output logic [2:0]          level,
    output logic                full,
    output logic                empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]          level_q, level_d;
    logic                do_push, do_pop;

    always_comb begin
        full     = (level_q == 3'(FIFO_DEPTH));
        empty    = (level_q == 3'd0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/tqvp_jnms_pdm_tx.sv
// PDM transmitter: register file, pdm_clk divider, OSR counter and first-order
// sigma-delta modulator fed from a 4-entry sample FIFO.
module tqvp_jnms_pdm_tx
    import tqvp_jnms_pdm_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic                en_q, en_d, irq_en_q, irq_en_d;
    logic [7:0]          half_q, half_d, osr_q, osr_d;
    logic [2:0]          thresh_q, thresh_d;
    logic                underrun_q, underrun_d, overflow_q, overflow_d;
    logic [7:0]          div_cnt_q, div_cnt_d, osr_cnt_q, osr_cnt_d;
    logic                pdm_clk_q, pdm_clk_d, pdm_data_q, pdm_data_d;
    logic                started_q, started_d;
    logic [SAMPLE_W-1:0] acc_q, acc_d, cur_q, cur_d;

    wr_size_e            wr_size;
    logic                wr_any, wr_wide, wr_word, push;
    logic                div_hit, step, fetch;
    logic [SAMPLE_W-1:0] sample, fifo_rdata;
    logic [SAMPLE_W:0]   sum;
    logic [2:0]          fifo_level;
    logic                fifo_full, fifo_empty;

    assign wr_size = wr_size_e'(data_write_n);
    assign wr_any  = (wr_size != WR_NONE);
    assign wr_wide = (wr_size == WR_HALF) || (wr_size == WR_WORD);
    assign wr_word = (wr_size == WR_WORD);
    assign push    = wr_wide && (address == ADDR_DATA);

    pdm_tx_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fetch),
        .wdata (data_in[SAMPLE_W-1:0]),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        half_d   = half_q;
        osr_d    = osr_q;
        thresh_d = thresh_q;
        if (wr_any) begin
            case (address)
                ADDR_CTRL: begin
                    en_d     = data_in[0];
                    irq_en_d = data_in[1];
                end
                ADDR_HALF:   half_d   = data_in[7:0];
                ADDR_OSR:    osr_d    = data_in[7:0];
                ADDR_THRESH: thresh_d = data_in[2:0];
                default: ;
            endcase
        end
    end

    // Steps are gated by en_d so a disabling write never consumes a sample.
    always_comb begin
        div_hit = (div_cnt_q == half_q);
        step    = en_q && en_d && (!started_q || (div_hit && pdm_clk_q));
        fetch   = step && (osr_cnt_q == 8'd0);
        sample  = fetch ? (fifo_empty ? '0 : fifo_rdata) : cur_q;
        sum     = {1'b0, acc_q} + {1'b0, sample ^ SIGN_FLIP};

        started_d  = en_d && (started_q || step);
        div_cnt_d  = '0;
        osr_cnt_d  = '0;
        pdm_clk_d  = 1'b0;
        pdm_data_d = 1'b0;
        acc_d      = '0;
        cur_d      = '0;
        if (en_d && en_q) begin
            div_cnt_d  = div_hit ? 8'd0 : div_cnt_q + 8'd1;
            pdm_clk_d  = pdm_clk_q ^ div_hit;
            osr_cnt_d  = osr_cnt_q;
            pdm_data_d = pdm_data_q;
            acc_d      = acc_q;
            cur_d      = cur_q;
            if (step) begin
                osr_cnt_d  = (osr_cnt_q >= osr_q) ? 8'd0 : osr_cnt_q + 8'd1;
                pdm_data_d = sum[SAMPLE_W];
                acc_d      = sum[SAMPLE_W-1:0];
                cur_d      = sample;
            end
        end
    end

    // Setting a sticky flag wins over a clear in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (wr_word && (address == ADDR_STATUS)) begin
            if (data_in[ST_UNDERRUN]) underrun_d = 1'b0;
            if (data_in[ST_OVERFLOW]) overflow_d = 1'b0;
        end
        if (fetch && fifo_empty)            underrun_d = 1'b1;
        if (push && fifo_full && !fetch)    overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            half_q     <= '0;
            osr_q      <= '0;
            thresh_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            div_cnt_q  <= '0;
            osr_cnt_q  <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= 1'b0;
            started_q  <= 1'b0;
            acc_q      <= '0;
            cur_q      <= '0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            half_q     <= half_d;
            osr_q      <= osr_d;
            thresh_q   <= thresh_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            div_cnt_q  <= div_cnt_d;
            osr_cnt_q  <= osr_cnt_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
            started_q  <= started_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL:   data_out[1:0] = {irq_en_q, en_q};
            ADDR_HALF:   data_out[7:0] = half_q;
            ADDR_OSR:    data_out[7:0] = osr_q;
            ADDR_THRESH: data_out[2:0] = thresh_q;
            ADDR_STATUS: begin
                data_out[2:0]        = fifo_level;
                data_out[ST_FULL]    = fifo_full;
                data_out[ST_EMPTY]   = fifo_empty;
                data_out[ST_UNDERRUN] = underrun_q;
                data_out[ST_OVERFLOW] = overflow_q;
            end
            default: ;
        endcase
    end

    assign uo_out         = {5'b0, pdm_data_q, pdm_clk_q, 1'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_en_q && en_q && (fifo_level <= thresh_q);

    logic unused_inputs;
    assign unused_inputs = ^{ui_in, data_read_n, data_in[31:18]};

endmodule

// File: tb/tb_tqvp_jnms_pdm_tx.sv
// Bench for the PDM transmitter: a sigma-delta reference model fills a bit queue,
// a monitor pops one bit per pdm_clk rising edge and also checks the high-phase length.
module tb_tqvp_jnms_pdm_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in, uo_out;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready, user_interrupt;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    int exp_half = 0;
    bit mon_on = 1'b0;
    int m_acc = 0;

    always #5 clk = ~clk;

    tqvp_jnms_pdm_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = w;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = data_out;
    endtask

    // Reference sigma-delta: accumulate offset-binary sample, emit the carry.
    task automatic model_sample(input logic [15:0] smp, input int nbits);
        int u;
        u = int'(smp ^ 16'h8000);
        for (int i = 0; i < nbits; i++) begin
            m_acc = m_acc + u;
            exp_q.push_back(m_acc >= 65536);
            m_acc = m_acc % 65536;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bits left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_stream(input int half, input int osr, input logic [15:0] smp[$]);
        int n, m;
        logic [31:0] st, exp_st;
        n = smp.size();
        m = (n > 4) ? 4 : n;
        bus_write(6'h10, 32'h0003_0000, 2'b10);
        bus_write(6'h04, 32'(half), 2'b10);
        bus_write(6'h08, 32'(osr), 2'b01);
        foreach (smp[i]) bus_write(6'h0C, {16'($urandom), smp[i]}, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
        exp_st = 32'(m);
        if (m == 4) exp_st[8] = 1'b1;
        if (n > 4)  exp_st[17] = 1'b1;
        rd(6'h10, st);
        chk("status_loaded", st, exp_st);
        if (n > 4) begin
            bus_write(6'h10, 32'h0002_0000, 2'b10);
            exp_st[17] = 1'b0;
            rd(6'h10, st);
            chk("overflow_clear", st, exp_st);
        end
        m_acc = 0;
        for (int i = 0; i < m; i++) model_sample(smp[i], osr + 1);
        model_sample(16'h0000, 2 * (osr + 1));
        exp_half = half;
        mon_on = 1'b1;
        bus_write(6'h00, 32'h1, 2'b00);
        wait_drain((m + 2) * (osr + 1) * 2 * (half + 1) + 40);
        mon_on = 1'b0;
        bus_write(6'h00, 32'h0, 2'b00);
        chk("idle_out", 32'(uo_out), 32'h0);
        rd(6'h10, st);
        chk("status_drained", st, 32'h0001_0200);
    endtask

    // Monitor: one expected bit per rising pdm_clk; high phase must last HALF+1 cycles.
    initial begin : monitor
        bit prev_pc;
        bit want;
        int hi_cnt;
        prev_pc = 1'b0;
        hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (uo_out[1] === 1'b1 && !prev_pc) begin
                hi_cnt = 1;
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    checks++;
                    if (uo_out[2] !== want) begin
                        errors++;
                        $display("FAIL pdm_bit: got %0b want %0b", uo_out[2], want);
                    end
                end
            end else if (uo_out[1] === 1'b1) begin
                hi_cnt++;
            end else if (prev_pc && mon_on) begin
                checks++;
                if (hi_cnt != exp_half + 1) begin
                    errors++;
                    $display("FAIL clk_high_len: got %0d want %0d", hi_cnt, exp_half + 1);
                end
            end
            prev_pc = (uo_out[1] === 1'b1);
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] v, st;
        logic [15:0] smp[$];
        logic [15:0] s0, s1;
        bit found;
        int n, cnt;

        rst_n = 1'b0;
        ui_in = '0;
        address = '0;
        data_in = '0;
        data_write_n = 2'b11;
        data_read_n = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 6; a++) begin
            rd(6'(a * 4), v);
            chk("reset_reg", v, (a == 4) ? 32'h200 : 32'h0);
        end
        chk("reset_uo", 32'(uo_out), 32'h0);
        chk("reset_irq", 32'(user_interrupt), 32'h0);
        chk("data_ready", 32'(data_ready), 32'h1);

        bus_write(6'h04, 32'hFFFF_FFA5, 2'b10);
        rd(6'h04, v);
        chk("half_readback", v, 32'hA5);
        bus_write(6'h14, 32'hFF, 2'b00);
        rd(6'h14, v);
        chk("thresh_readback", v, 32'h7);
        bus_write(6'h14, 32'h0, 2'b00);
        bus_write(6'h0C, 32'h1234, 2'b00);
        rd(6'h10, v);
        chk("byte_data_ignored", v, 32'h200);

        smp = '{16'h4000};
        run_stream(1, 3, smp);
        smp = '{16'h8000, 16'h7FFF};
        run_stream(2, 7, smp);
        smp = '{16'h1111, 16'hC000, 16'h7FFF, 16'h8000, 16'h5555};
        run_stream(0, 2, smp);

        for (int r = 0; r < 12; r++) begin
            smp.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       smp.push_back(16'h8000);
                    1:       smp.push_back(16'h7FFF);
                    default: smp.push_back(16'($urandom));
                endcase
            end
            run_stream($urandom_range(0, 3), $urandom_range(0, 7), smp);
        end

        // Low-water interrupt.
        bus_write(6'h10, 32'h0003_0000, 2'b10);
        bus_write(6'h04, 32'h1, 2'b00);
        bus_write(6'h08, 32'h3, 2'b00);
        bus_write(6'h14, 32'h1, 2'b00);
        for (int i = 0; i < 3; i++) bus_write(6'h0C, 32'($urandom), 2'b01);
        chk("irq_while_off", 32'(user_interrupt), 32'h0);
        bus_write(6'h00, 32'h3, 2'b00);
        chk("irq_level3", 32'(user_interrupt), 32'h0);
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 200) begin
            rd(6'h10, st);
            cnt++;
            if (st[2:0] == 3'd1) found = 1'b1;
        end
        chk("irq_level1_seen", 32'(found), 32'h1);
        chk("irq_at_level1", 32'(user_interrupt), 32'h1);
        bus_write(6'h0C, 32'($urandom), 2'b01);
        chk("irq_after_push", 32'(user_interrupt), 32'h0);
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 400) begin
            rd(6'h10, st);
            cnt++;
            if (st[9]) found = 1'b1;
        end
        chk("irq_empty_seen", 32'(found), 32'h1);
        chk("irq_at_empty", 32'(user_interrupt), 32'h1);
        bus_write(6'h00, 32'h0, 2'b00);
        chk("irq_after_disable", 32'(user_interrupt), 32'h0);

        // Disable mid-sample, then re-enable: fresh sample and cleared accumulator.
        bus_write(6'h10, 32'h0003_0000, 2'b10);
        bus_write(6'h04, 32'h3, 2'b00);
        bus_write(6'h08, 32'h7, 2'b00);
        s0 = 16'($urandom);
        s1 = 16'($urandom);
        bus_write(6'h0C, {16'h0, s0}, 2'b01);
        bus_write(6'h0C, {16'h0, s1}, 2'b01);
        m_acc = 0;
        model_sample(s0, 3);
        exp_half = 3;
        mon_on = 1'b1;
        bus_write(6'h00, 32'h1, 2'b00);
        wait_drain(3 * 8 + 40);
        mon_on = 1'b0;
        bus_write(6'h00, 32'h0, 2'b00);
        chk("clear_pdm_clk", 32'(uo_out[1]), 32'h0);
        chk("clear_pdm_data", 32'(uo_out[2]), 32'h0);
        rd(6'h10, st);
        chk("clear_status", st, 32'h1);
        m_acc = 0;
        model_sample(s1, 8);
        model_sample(16'h0000, 16);
        mon_on = 1'b1;
        bus_write(6'h00, 32'h1, 2'b00);
        wait_drain(3 * 8 * 8 + 40);
        mon_on = 1'b0;
        bus_write(6'h00, 32'h0, 2'b00);
        rd(6'h10, st);
        chk("reenable_status", st, 32'h0001_0200);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
